// File: rtl/dropout_stage.sv
// Dropout layer stage: LFSR-driven element drop with 1/(1-p) keep-scaling in training,
// pass-through otherwise. Three register stages give a fixed two-cycle accept-to-output latency.
module dropout_stage #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_ELEMS   = 9,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] DROP_THRESH = 16'h4000,
  parameter int unsigned SCALE_Q     = 171
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  train_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_drop,
  output logic                  done
);

  localparam int unsigned CNT_W  = $clog2(NUM_ELEMS + 1);
  localparam int unsigned PROD_W = DATA_WIDTH + 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FINISH} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      in_cnt_reg, out_cnt_reg;
  logic [15:0]           lfsr_reg;
  logic [15:0]           lfsr_next;
  logic                  accept, last_in, last_out, start_map;

  // Stage 1: captured element and its drop decision
  logic                  s1_valid_reg, s1_drop_reg, s1_train_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  // Stage 2: scaled product alongside the raw element
  logic                  s2_valid_reg, s2_drop_reg, s2_train_reg;
  logic [DATA_WIDTH-1:0] s2_data_reg;
  logic [PROD_W-1:0]     s2_scaled_reg;
  logic [PROD_W-1:0]     product;
  logic [DATA_WIDTH-1:0] result;

  logic                  out_valid_reg, out_drop_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;

  assign accept    = (state_reg == RUN) && in_valid;
  assign last_in   = accept && (in_cnt_reg == CNT_W'(NUM_ELEMS - 1));
  assign last_out  = out_valid_reg && (out_cnt_reg == CNT_W'(NUM_ELEMS - 1));
  assign start_map = (state_reg == IDLE) && start;
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_in)  state_next = FLUSH;
      FLUSH:   if (last_out) state_next = FINISH;
      FINISH:  if (!start)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      lfsr_reg    <= LFSR_SEED;
    end else if (start_map) begin
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      lfsr_reg    <= LFSR_SEED;
    end else begin
      if (accept) begin
        in_cnt_reg <= in_cnt_reg + 1'b1;
      end
      // The sequence only moves in training so pass-through maps do not perturb it
      if (accept && train_en) begin
        lfsr_reg <= lfsr_next;
      end
      if (out_valid_reg) begin
        out_cnt_reg <= out_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_drop_reg  <= 1'b0;
      s1_train_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_data_reg  <= in_data;
        s1_train_reg <= train_en;
        s1_drop_reg  <= train_en && (lfsr_reg < DROP_THRESH);
      end
    end
  end

  assign product = PROD_W'(s1_data_reg) * PROD_W'(SCALE_Q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_drop_reg   <= 1'b0;
      s2_train_reg  <= 1'b0;
      s2_data_reg   <= '0;
      s2_scaled_reg <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg   <= s1_data_reg;
        s2_drop_reg   <= s1_drop_reg;
        s2_train_reg  <= s1_train_reg;
        s2_scaled_reg <= product >> 7;
      end
    end
  end

  always_comb begin
    result = s2_scaled_reg[DATA_WIDTH-1:0];
    if (!s2_train_reg) begin
      result = s2_data_reg;
    end else if (s2_drop_reg) begin
      result = '0;
    end else if (|s2_scaled_reg[PROD_W-1:DATA_WIDTH]) begin
      result = '1;
    end
  end

  // Output registers only load on valid so out_data holds between elements
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_drop_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_data_reg <= result;
        out_drop_reg <= s2_drop_reg;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_drop  = out_drop_reg;
  assign done      = (state_reg == FINISH);

endmodule

// File: tb/tb_dropout_stage.sv
// Table-driven bench for dropout_stage: a default-threshold instance and an always-drop
// instance share stimulus; outputs are collected on the falling edge and compared in order.
module tb_dropout_stage;

  localparam int N = 9;

  logic       clk = 1'b0;
  logic       rst, start, train_en, in_valid;
  logic [7:0] in_data;
  logic [7:0] out_data, out_data_hi;
  logic       out_valid, out_drop, done;
  logic       out_valid_hi, out_drop_hi, done_hi;

  always #5 clk = ~clk;

  dropout_stage dut (
    .clk(clk), .rst(rst), .start(start), .train_en(train_en),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_drop(out_drop), .done(done)
  );

  dropout_stage #(.DROP_THRESH(16'hFFFF)) dut_hi (
    .clk(clk), .rst(rst), .start(start), .train_en(train_en),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_hi), .out_valid(out_valid_hi), .out_drop(out_drop_hi), .done(done_hi)
  );

  typedef struct {
    logic       train;
    logic [7:0] din;
    logic [7:0] dexp;
    logic       drop_exp;
  } vec_t;

  vec_t vt[0:39];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int first_cyc = -1;
  logic [8:0] out_q[$];
  logic [8:0] hi_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      out_q.push_back({out_drop, out_data});
      pulse_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (out_valid_hi) hi_q.push_back({out_drop_hi, out_data_hi});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic setv(input int idx, input bit tr, input int din, input int dexp, input bit dd);
    vt[idx].train    = tr;
    vt[idx].din      = 8'(din);
    vt[idx].dexp     = 8'(dexp);
    vt[idx].drop_exp = dd;
  endtask

  task automatic clear_mon();
    out_q.delete();
    hi_q.delete();
    pulse_cnt = 0;
    first_cyc = -1;
  endtask

  task automatic feed(input int base, input int n, input bit gaps, output int acc_cyc);
    acc_cyc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vt[base+i].din;
      train_en = vt[base+i].train;
      tick();
      if (i == 0) acc_cyc = cyc;
      in_valid = 1'b0;
      if (gaps && (i % 3 == 1)) tick();
      if (gaps && (i % 4 == 3)) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 60) begin
      tick();
      k++;
    end
    check(name, done, 1);
  endtask

  task automatic compare_map(input string tag, input int base, input int n, input bit chk_hi);
    logic [8:0] hexp;
    check({tag, "_count"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), out_q[i][7:0], vt[base+i].dexp);
      check($sformatf("%s_drop%0d", tag, i), out_q[i][8], vt[base+i].drop_exp);
    end
    if (chk_hi) begin
      check({tag, "_hi_count"}, hi_q.size(), n);
      for (int i = 0; i < n && i < hi_q.size(); i++) begin
        hexp = vt[base+i].train ? 9'h100 : {1'b0, vt[base+i].din};
        check($sformatf("%s_hi%0d", tag, i), hi_q[i], hexp);
      end
    end
  endtask

  initial begin
    int acc;
    // 0..8: pass-through ramp
    for (int i = 0; i < 9; i++) setv(i, 1'b0, i, i, 1'b0);
    // 9..17: training, LFSR ACE1 59C3 B387 670F CE1E 9C3C 3879 70F2 E1E4
    setv(9,  1'b1, 100, 133, 1'b0);
    setv(10, 1'b1, 100, 133, 1'b0);
    setv(11, 1'b1, 100, 133, 1'b0);
    setv(12, 1'b1, 100, 133, 1'b0);
    setv(13, 1'b1, 96,  128, 1'b0);
    setv(14, 1'b1, 255, 255, 1'b0);
    setv(15, 1'b1, 50,  0,   1'b1);
    setv(16, 1'b1, 150, 200, 1'b0);
    setv(17, 1'b1, 0,   0,   1'b0);
    // 18..26: mixed train_en, LFSR advances only on training elements
    setv(18, 1'b1, 100, 133, 1'b0);
    setv(19, 1'b0, 100, 100, 1'b0);
    setv(20, 1'b1, 100, 133, 1'b0);
    setv(21, 1'b0, 7,   7,   1'b0);
    setv(22, 1'b1, 96,  128, 1'b0);
    setv(23, 1'b1, 10,  13,  1'b0);
    setv(24, 1'b1, 20,  26,  1'b0);
    setv(25, 1'b1, 30,  40,  1'b0);
    setv(26, 1'b1, 40,  0,   1'b1);
    // 27..36: ten gapped pass-through inputs, the tenth must be ignored
    for (int i = 0; i < 10; i++) setv(27 + i, 1'b0, 10 * i + 3, 10 * i + 3, 1'b0);

    rst = 1'b1; start = 1'b0; train_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_drop", out_drop, 0);
    rst = 1'b0;
    tick();

    // pass-through ramp with latency and done hold
    clear_mon();
    start = 1'b1;
    tick();
    feed(0, 9, 1'b0, acc);
    wait_done("ramp_done");
    compare_map("ramp", 0, 9, 1'b1);
    check("ramp_latency", first_cyc - acc, 2);
    repeat (3) tick();
    check("ramp_done_hold", done, 1);
    check("ramp_pulses", pulse_cnt, 9);
    start = 1'b0;
    tick();
    check("ramp_done_clear", done, 0);

    // reset after four accepts discards in-flight work
    clear_mon();
    start = 1'b1;
    tick();
    feed(9, 4, 1'b0, acc);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    clear_mon();
    rst = 1'b0;
    start = 1'b0;
    repeat (8) tick();
    check("midrst_pulses", pulse_cnt, 0);
    check("midrst_done", done, 0);

    // training map after restart reproduces the seed sequence
    clear_mon();
    start = 1'b1;
    tick();
    feed(9, 9, 1'b0, acc);
    wait_done("train_done");
    compare_map("train", 9, 9, 1'b1);
    check("train_hold_data", out_data, 0);
    start = 1'b0;
    tick();

    // per-element train_en
    clear_mon();
    start = 1'b1;
    tick();
    feed(18, 9, 1'b0, acc);
    wait_done("mixed_done");
    compare_map("mixed", 18, 9, 1'b1);
    start = 1'b0;
    tick();

    // gapped input, surplus element ignored, done held with start
    clear_mon();
    start = 1'b1;
    tick();
    feed(27, 10, 1'b1, acc);
    wait_done("gap_done");
    compare_map("gap", 27, 9, 1'b0);
    repeat (4) tick();
    check("gap_done_hold", done, 1);
    check("gap_pulses", pulse_cnt, 9);
    start = 1'b0;
    tick();
    check("gap_done_clear", done, 0);
    tick();
    check("gap_idle", done, 0);
    check("gap_idle_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dropout_stage.md
DROPOUT_STAGE -- requirements
Module: dropout_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning element width (unsigned).
REQ-002 SHALL have parameter NUM_ELEMS, default 9, meaning elements per feature map (upstream pool output size).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning LFSR load value (nonzero).
REQ-004 SHALL have parameter DROP_THRESH, default 16'h4000, meaning drop when LFSR < DROP_THRESH (p = DROP_THRESH/65536).
REQ-005 SHALL have parameter SCALE_Q, default 171, meaning keep-scale 1/(1-p) in unsigned fixed point with 7 fraction bits.
REQ-006 SHALL have one clock and one reset: the clock SHALL be named clk; the reset SHALL be named rst and SHALL be synchronous and active-high.
REQ-007 SHALL have ports:
  clk        in   1           clock, rising edge
  rst        in   1           synchronous active-high reset
  start      in   1           begin a feature map (level, held by controller)
  train_en   in   1           1: dropout+scale, 0: pass-through
  in_data    in   DATA_WIDTH  element from max-pool
  in_valid   in   1           in_data valid this cycle
  out_data   out  DATA_WIDTH  processed element
  out_valid  out  1           out_data valid this cycle
  out_drop   out  1           element was dropped (qualified by out_valid)
  done       out  1           all NUM_ELEMS outputs emitted

Function
REQ-008 SHALL implement FSM states IDLE, RUN, FLUSH, FINISH.
REQ-009 IDLE -> RUN when start=1; on this transition the LFSR SHALL reload LFSR_SEED and both counters SHALL clear.
REQ-010 In RUN, each cycle with in_valid=1 SHALL accept one element and increment in_cnt; in_valid outside RUN SHALL be ignored.
REQ-011 RUN -> FLUSH on the cycle the NUM_ELEMS-th element is accepted; FLUSH -> FINISH on the cycle the NUM_ELEMS-th output is emitted; FINISH -> IDLE when start=0.
REQ-012 done SHALL be 1 exactly while in FINISH.
REQ-013 LFSR: 16-bit Fibonacci, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; SHALL advance once per accepted element only when train_en=1.
REQ-014 Drop decision SHALL use the LFSR value before that element's advance: drop = train_en & (lfsr < DROP_THRESH).
REQ-015 Pipeline: stage 1 registers data and drop; stage 2 computes result; out_valid SHALL rise exactly 2 cycles after the accepting edge; one output per accepted element, in order, no bubbles added.
REQ-016 train_en=0: out_data = in_data, out_drop=0.
REQ-017 train_en=1, dropped: out_data = 0, out_drop=1.
REQ-018 train_en=1, kept: out_data = min((in_data*SCALE_Q) >> 7, 2^DATA_WIDTH-1); product SHALL be computed at DATA_WIDTH+8 bits, truncated (no rounding), saturating.
REQ-019 train_en SHALL be sampled per element at acceptance and carried down the pipeline.
REQ-020 out_cnt SHALL count out_valid pulses; in_valid beyond NUM_ELEMS SHALL be ignored.
REQ-021 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-022 On rst=1 at a clock edge: state IDLE, counters 0, LFSR = LFSR_SEED, pipeline valids cleared, out_data=0, out_valid=0, out_drop=0, done=0.
REQ-023 rst SHALL take priority over all other inputs, including mid-RUN; in-flight elements SHALL be discarded with no out_valid after reset.

Verification
REQ-024 train_en=0, start, 9 back-to-back inputs 0..8 -> outputs 0..8, first out_valid 2 cycles after first accept, done after 9th output.
REQ-025 train_en=1, DROP_THRESH=16'h4000, 4 inputs of 100 -> LFSR ACE1,59C3,B387,670F all keep -> four outputs of 133, out_drop=0.
REQ-026 train_en=1, inputs 96 and 255 with no drop -> outputs 128 and 255 (saturated).
REQ-027 DROP_THRESH=16'hFFFF, train_en=1, input 50 -> out_data=0, out_drop=1.
REQ-028 rst asserted after 4 of 9 accepts -> no further out_valid, done=0, restart with start reproduces REQ-025 LFSR sequence.
REQ-029 10 inputs with gaps in in_valid, start held -> exactly 9 outputs, done held until start=0, then IDLE.
